// File: rtl/apb_req_bridge.sv
// APB requester bridge: queued requests in, APB transfers out, responses back.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase timeout.
//
// Ports:
//   pclk, presetn          clock, async active-low reset
//   paddr..pstrb, psel     APB requester outputs (pnse tied 0)
//   pready/prdata/pslverr  completer inputs
//   req_*                  request valid/ready channel (REQ_DEPTH FIFO)
//   rsp_*                  response valid/ready channel (2-entry FIFO)
module apb_req_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_DEPTH      = 4,
  parameter int NUM_SEL        = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    pnse,
  output logic [NUM_SEL-1:0]      psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int SB = $clog2(NUM_SEL);
  localparam int PW = $clog2(REQ_DEPTH);
  localparam int QW = 1 + ADDR_WIDTH + DATA_WIDTH + SW + 3;
  localparam int RW = DATA_WIDTH + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0] state_q, state_d;
  logic       is_access, fin_ok, fin_to, fin, launch;

  // ---------------- request FIFO ----------------
  logic [QW-1:0] rq_mem [REQ_DEPTH];
  logic [PW-1:0] rq_wp_q, rq_rp_q;
  logic [PW:0]   rq_cnt_q;
  logic          rq_empty, rq_full, rq_push;
  logic          rq_wr, rq_rd, have_req;
  logic [QW-1:0] rq_in, rq_head;

  logic                  h_write;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [SW-1:0]         h_strb;
  logic [2:0]            h_prot;

  assign rq_empty  = (rq_cnt_q == '0);
  assign rq_full   = (rq_cnt_q == (PW+1)'(REQ_DEPTH));
  assign req_ready = presetn & ~rq_full;
  assign rq_push   = req_valid & req_ready;
  assign rq_in     = {req_write, req_addr, req_wdata,
                      req_strb, req_prot};

  // An empty FIFO forwards the incoming request so a
  // request can start SETUP in the cycle after it is taken.
  assign rq_head  = rq_empty ? rq_in : rq_mem[rq_rp_q];
  assign have_req = ~rq_empty | rq_push;
  assign rq_wr    = rq_push & ~(launch & rq_empty);
  assign rq_rd    = launch & ~rq_empty;

  assign {h_write, h_addr, h_wdata, h_strb, h_prot} = rq_head;

  always_ff @(posedge pclk) begin
    if (rq_wr) rq_mem[rq_wp_q] <= rq_in;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rq_wp_q  <= '0;
      rq_rp_q  <= '0;
      rq_cnt_q <= '0;
    end else begin
      if (rq_wr) rq_wp_q <= rq_wp_q + 1'b1;
      if (rq_rd) rq_rp_q <= rq_rp_q + 1'b1;
      rq_cnt_q <= rq_cnt_q + (PW+1)'(rq_wr)
                           - (PW+1)'(rq_rd);
    end
  end

  // ---------------- response FIFO ----------------
  logic [RW-1:0] rs_mem [2];
  logic          rs_wp_q, rs_rp_q;
  logic [1:0]    rs_cnt_q;
  logic          rs_pop, rs_clear;
  logic [RW-1:0] rs_din;

  assign rsp_valid = (rs_cnt_q != 2'd0);
  assign rs_pop    = rsp_valid & rsp_ready;
  // Occupancy left after this cycle's pop, ignoring the
  // entry a completing transfer writes now. Keeping this
  // at zero before launching bounds the FIFO to 2 entries.
  assign rs_clear  = ((rs_cnt_q - {1'b0, rs_pop}) == 2'd0);

  assign {rsp_rdata, rsp_err, rsp_timeout} = rs_mem[rs_rp_q];

  assign rs_din = fin_ok
    ? {(pwrite ? {DATA_WIDTH{1'b0}} : prdata), pslverr, 1'b0}
    : {{DATA_WIDTH{1'b0}}, 2'b11};

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rs_mem[0] <= '0;
      rs_mem[1] <= '0;
      rs_wp_q   <= 1'b0;
      rs_rp_q   <= 1'b0;
      rs_cnt_q  <= 2'd0;
    end else begin
      if (fin) begin
        rs_mem[rs_wp_q] <= rs_din;
        rs_wp_q         <= ~rs_wp_q;
      end
      if (rs_pop) rs_rp_q <= ~rs_rp_q;
      rs_cnt_q <= rs_cnt_q + {1'b0, fin} - {1'b0, rs_pop};
    end
  end

  // ---------------- transfer control ----------------
  assign is_access = (state_q == S_ACCESS);
  assign fin_ok    = is_access & pready;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  assign fin_to = is_access & ~pready &
                  (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      to_cnt_q <= '0;
    else if (launch)
      to_cnt_q <= '0;
    else if (is_access & ~pready)
      to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign fin_to = 1'b0;
`endif

  assign fin    = fin_ok | fin_to;
  assign launch = have_req & rs_clear &
                  ((state_q == S_IDLE) | fin);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (launch) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (fin) state_d = launch ? S_SETUP : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- APB output registers ----------------
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [2:0]            pprot_q;
  logic [NUM_SEL-1:0]    psel_q, sel_dec;
  logic                  penable_q, pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [SW-1:0]         pstrb_q;

  assign sel_dec = (NUM_SEL)'(1) << h_addr[SEL_LSB +: SB];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr_q   <= '0;
      pprot_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
    end else if (launch) begin
      paddr_q   <= h_addr;
      pprot_q   <= h_prot;
      psel_q    <= sel_dec;
      penable_q <= 1'b0;
      pwrite_q  <= h_write;
      pwdata_q  <= h_wdata;
      pstrb_q   <= h_write ? h_strb : '0;
    end else if (state_q == S_SETUP) begin
      penable_q <= 1'b1;
    end else if (fin) begin
      psel_q    <= '0;
      penable_q <= 1'b0;
    end
  end

  assign paddr   = paddr_q;
  assign pprot   = pprot_q;
  assign pnse    = 1'b0;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: phase-level model
// with request/response queues plus directed literal checks.
module tb_apb_req_bridge;

  localparam int TOC   = 8;
  localparam int DEPTH = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        pnse;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;

  always #5 pclk = ~pclk;

  apb_req_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REQ_DEPTH(DEPTH),
    .NUM_SEL(4), .SEL_LSB(12), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .paddr(paddr), .pprot(pprot), .pnse(pnse),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, got, exp, $time);
    end
  endtask

  // ---------------- completer responder ----------------
  int          ws = 0;
  bit          never = 1'b0;
  bit          slverr_en = 1'b0;
  logic [31:0] rd_base = 32'hCAFE_0000;
  int          acnt = 0;

  always @(posedge pclk) begin
    #1;
    if (presetn && psel != 0 && penable) begin
      pready = !never && (acnt == ws);
      acnt++;
    end else begin
      pready = 1'b0;
      acnt = 0;
    end
    prdata  = rd_base ^ paddr;
    pslverr = slverr_en;
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
  } req_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        t;
  } rsp_t;

  req_t pend[$];
  rsp_t rq[$];
  req_t cur = '0;
  int   ph = 0;
  int   acc_n = 0;
  int   n_setup = 0;
  int   n_pop = 0;

  always @(negedge pclk) begin : mon
    bit   done;
    int   nxt;
    rsp_t r;
    if (!presetn) begin
      pend.delete();
      rq.delete();
      ph = 0;
      acc_n = 0;
      cur = '0;
    end else begin
      chk("phase", {(psel != 0), penable},
          ph == 0 ? 2'b00 : (ph == 1 ? 2'b10 : 2'b11));
      if (ph == 1) begin
        if (pend.size() == 0) begin
          chk("setup_has_req", 0, 1);
        end else begin
          cur = pend.pop_front();
          n_setup++;
        end
        acc_n = 0;
      end
      chk("paddr", paddr, cur.a);
      chk("pwrite", pwrite, cur.w);
      chk("pwdata", pwdata, cur.d);
      chk("pstrb", pstrb, cur.w ? cur.s : 4'h0);
      chk("pprot", pprot, cur.p);
      chk("pnse", pnse, 0);
      if (ph != 0) chk("psel", psel, 4'b1 << cur.a[13:12]);
      chk("req_ready", req_ready, pend.size() < DEPTH);
      chk("rsp_valid", rsp_valid, rq.size() != 0);
      if (rq.size() != 0) begin
        chk("rsp_rdata", rsp_rdata, rq[0].d);
        chk("rsp_err", rsp_err, rq[0].e);
        chk("rsp_timeout", rsp_timeout, rq[0].t);
        if (rsp_ready) begin
          void'(rq.pop_front());
          n_pop++;
        end
      end
      if (req_valid && req_ready)
        pend.push_back({req_write, req_addr, req_wdata,
                        req_strb, req_prot});
      done = (ph == 2) && pready;
`ifdef APB_TIMEOUT_EN
      if (ph == 2 && !pready && acc_n == TOC - 1) done = 1'b1;
`endif
      if (ph == 2) acc_n++;
      if (ph == 1) nxt = 2;
      else if (ph == 2 && !done) nxt = 2;
      else if (pend.size() != 0 && rq.size() == 0) nxt = 1;
      else nxt = 0;
      if (done) begin
        if (pready) r = {(cur.w ? 32'h0 : prdata), pslverr, 1'b0};
        else        r = {32'h0, 1'b1, 1'b1};
        rq.push_back(r);
      end
      ph = nxt;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p);
    bit ok = 1'b0;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    req_prot  = p;
    req_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge pclk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("push_accept", ok, 1);
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_pops(input int target);
    for (int k = 0; k < 200; k++) begin
      @(negedge pclk);
      #1;
      if (n_pop >= target) break;
    end
    chk("drain", n_pop, target);
  endtask

  logic [31:0] b_addr [5] = '{32'h0010, 32'h1004, 32'h1008,
                               32'h2010, 32'h3FFC};
  logic [3:0]  b_strb [5] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h8};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, p0, pe;
    bit seen;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_paddr", paddr, 0);
    @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    chk("ready_after_reset", req_ready, 1);
    cyc(1);

    // single write, zero wait states
    push(1'b1, 32'h0000_2004, 32'hA5A5_5A5A, 4'hF, 3'b010);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("wr_setup_psel", psel, 4'b0100);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_pstrb", pstrb, 4'hF);
    @(negedge pclk);
    chk("wr_access_penable", penable, 1);
    @(negedge pclk);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_err", rsp_err, 0);
    cyc(1);

    // read with three wait states
    ws = 3;
    rd_base = 32'h1234_6678;
    push(1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 3'b001);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("rd_setup_psel", psel, 4'b1000);
    chk("rd_setup_pstrb", pstrb, 4'h0);
    pe = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (penable) pe++;
      else if (pe > 0) break;
    end
    chk("rd_penable_cycles", pe, 4);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_idle_psel", psel, 0);
    cyc(1);
    ws = 0;
    rd_base = 32'h0BAD_F00D;

    // five back-to-back writes
    s0 = n_setup;
    p0 = n_pop;
    for (int i = 0; i < 5; i++)
      push(1'b1, b_addr[i], 32'h1111_0000 + i, b_strb[i], 3'(i));
    req_valid = 1'b0;
    wait_pops(p0 + 5);
    chk("burst_setups", n_setup - s0, 5);
    cyc(1);

    // response back-pressure fills the request FIFO
    rsp_ready = 1'b0;
    s0 = n_setup;
    p0 = n_pop;
    for (int i = 0; i < 4; i++)
      push(1'b0, 32'h0100 + 32'h1000 * i, 32'h0, 4'hF, 3'b000);
    req_valid = 1'b0;
    cyc(20);
    @(negedge pclk);
    chk("stall_setups", n_setup - s0, 2);
    chk("stall_rsp_valid", rsp_valid, 1);
    cyc(1);
    push(1'b0, 32'h0000_0200, 32'h0, 4'hF, 3'b000);
    push(1'b0, 32'h0000_1200, 32'h0, 4'hF, 3'b000);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("full_req_ready", req_ready, 0);
    cyc(1);
    rsp_ready = 1'b1;
    wait_pops(p0 + 6);
    chk("stall_total_setups", n_setup - s0, 6);
    cyc(1);

    // slave error on a normal completion
    slverr_en = 1'b1;
    push(1'b1, 32'h0000_1000, 32'h5555_AAAA, 4'h6, 3'b100);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("slverr_seen", seen, 1);
    chk("slverr_err", rsp_err, 1);
    chk("slverr_timeout", rsp_timeout, 0);
    cyc(1);
    slverr_en = 1'b0;

`ifdef APB_TIMEOUT_EN
    // completer never answers
    never = 1'b1;
    push(1'b0, 32'h0000_2000, 32'h0, 4'hF, 3'b000);
    req_valid = 1'b0;
    @(negedge pclk);
    pe = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (penable) pe++;
      else if (pe > 0) break;
    end
    chk("to_penable_cycles", pe, TOC);
    chk("to_psel", psel, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    cyc(1);
    never = 1'b0;
`endif

    // reset in the middle of an ACCESS phase
    ws = 10;
    push(1'b0, 32'h0000_3000, 32'h0, 4'hF, 3'b000);
    req_valid = 1'b0;
    cyc(4);
    presetn = 1'b0;
    @(negedge pclk);
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    cyc(2);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    cyc(15);
    @(negedge pclk);
    chk("no_rsp_after_reset", rsp_valid, 0);
    ws = 0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
